// File: rtl/controller_mc_pkg.sv
// Shared definitions for the multicycle controller: FSM states, opcodes,
// ALU operation codes and datapath mux-select encodings.
package controller_mc_pkg;

  // Controller FSM states
  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_TRAP
  } state_t;

  // Opcodes recognised by the decoder
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // funct3 values that select a specific ALU or branch operation
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  // ALU operation codes (3-bit core, zero-extended at the port)
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // ALU source A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  // ALU source B select
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result mux select
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Immediate format select
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format is a pure function of the opcode, independent of state
  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/controller_mc_if.sv
// Controller <-> datapath bundle: instruction fields and status in,
// strobes and mux selects out.
interface controller_mc_if #(
  parameter int ALU_CTRL_W = 3
);
  logic [6:0]            op;
  logic [2:0]            funct3;
  logic                  funct7b5;
  logic                  is_zero;
  logic                  mem_ready;

  logic                  pc_write;
  logic                  ir_write;
  logic                  adr_src;
  logic                  mem_write;
  logic                  reg_write;
  logic [1:0]            alu_src_a;
  logic [1:0]            alu_src_b;
  logic [1:0]            result_src;
  logic [1:0]            imm_src;
  logic [ALU_CTRL_W-1:0] alu_ctrl;
  logic                  retire;
  logic                  illegal;

  // Controller side
  modport master (
    input  op, funct3, funct7b5, is_zero, mem_ready,
    output pc_write, ir_write, adr_src, mem_write, reg_write,
           alu_src_a, alu_src_b, result_src, imm_src, alu_ctrl,
           retire, illegal
  );

  // Datapath side
  modport slave (
    output op, funct3, funct7b5, is_zero, mem_ready,
    input  pc_write, ir_write, adr_src, mem_write, reg_write,
           alu_src_a, alu_src_b, result_src, imm_src, alu_ctrl,
           retire, illegal
  );
endinterface

// File: rtl/controller_mc_alu_ctrl_dec.sv
// ALU operation decode for the execute states (R-type and I-type ALU ops).
module alu_ctrl_dec
  import controller_mc_pkg::*;
(
  input  logic       op5_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_op_o
);

  // funct3 picks the operation; funct7b5 only turns add into sub for R-type
  always_comb begin
    alu_op_o = ALU_ADD;
    case (funct3_i)
      F3_ADD:  alu_op_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
      F3_SLT:  alu_op_o = ALU_SLT;
      F3_OR:   alu_op_o = ALU_OR;
      F3_AND:  alu_op_o = ALU_AND;
      default: alu_op_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/controller_mc.sv
// Multicycle RISC-V style controller: state register plus per-state
// datapath control decode. Strobes are forced low while reset is held.
module controller_mc
  import controller_mc_pkg::*;
#(
  parameter int ALU_CTRL_W       = 3,
  parameter int BNE_EN           = 1,
  parameter int RESET_STATE_TRAP = 0
) (
  input logic            clk,
  input logic            rst,
  controller_mc_if.master bus
);

  localparam state_t RESET_STATE = (RESET_STATE_TRAP != 0) ? S_TRAP : S_FETCH;

  state_t     state_q, state_d;
  logic [2:0] exec_alu_op;

  logic       pc_write_c, ir_write_c, adr_src_c, mem_write_c, reg_write_c, retire_c;
  logic [1:0] src_a_c, src_b_c, res_c;
  logic [2:0] alu_c;
  logic       br_valid, br_taken;

  alu_ctrl_dec u_alu_ctrl_dec (
    .op5_i      (bus.op[5]),
    .funct3_i   (bus.funct3),
    .funct7b5_i (bus.funct7b5),
    .alu_op_o   (exec_alu_op)
  );

  // Only beq, and bne when enabled, are legal branches
  assign br_valid = (bus.funct3 == F3_BEQ) || ((BNE_EN != 0) && (bus.funct3 == F3_BNE));
  assign br_taken = (bus.funct3 == F3_BEQ) ? bus.is_zero : !bus.is_zero;

  // State register; reset takes effect immediately, not at the next edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RESET_STATE;
    else     state_q <= state_d;
  end

  // Next-state and per-state control decode
  always_comb begin
    state_d     = state_q;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    adr_src_c   = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    retire_c    = 1'b0;
    src_a_c     = SRCA_PC;
    src_b_c     = SRCB_REG;
    res_c       = RES_ALUOUT;
    alu_c       = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        src_b_c    = SRCB_FOUR;
        res_c      = RES_ALU;
        ir_write_c = bus.mem_ready;
        pc_write_c = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch target PC+imm is precomputed here
        src_a_c = SRCA_OLDPC;
        src_b_c = SRCB_IMM;
        case (bus.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_ITYPE:          state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        src_a_c = SRCA_REG;
        src_b_c = SRCB_IMM;
        state_d = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src_c = 1'b1;
        res_c     = RES_ALUOUT;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        res_c       = RES_DATA;
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        // Write strobe is held until memory accepts it
        adr_src_c   = 1'b1;
        mem_write_c = 1'b1;
        if (bus.mem_ready) begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_EXEC_R: begin
        src_a_c = SRCA_REG;
        src_b_c = SRCB_REG;
        alu_c   = exec_alu_op;
        state_d = S_ALUWB;
      end
      S_EXEC_I: begin
        src_a_c = SRCA_REG;
        src_b_c = SRCB_IMM;
        alu_c   = exec_alu_op;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        res_c       = RES_ALUOUT;
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        src_a_c = SRCA_REG;
        src_b_c = SRCB_REG;
        alu_c   = ALU_SUB;
        res_c   = RES_ALUOUT;
        if (br_valid) begin
          pc_write_c = br_taken;
          retire_c   = 1'b1;
          state_d    = S_FETCH;
        end else begin
          state_d = S_TRAP;
        end
      end
      S_JAL: begin
        src_a_c     = SRCA_OLDPC;
        src_b_c     = SRCB_FOUR;
        res_c       = RES_ALUOUT;
        pc_write_c  = 1'b1;
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_TRAP: begin
        // Absorbing; only reset leaves
        state_d = S_TRAP;
      end
      default: state_d = S_TRAP;
    endcase
  end

  // Strobes are gated by reset so an interrupted access drops immediately
  assign bus.pc_write   = pc_write_c  & ~rst;
  assign bus.ir_write   = ir_write_c  & ~rst;
  assign bus.adr_src    = adr_src_c;
  assign bus.mem_write  = mem_write_c & ~rst;
  assign bus.reg_write  = reg_write_c & ~rst;
  assign bus.retire     = retire_c    & ~rst;
  assign bus.alu_src_a  = src_a_c;
  assign bus.alu_src_b  = src_b_c;
  assign bus.result_src = res_c;
  assign bus.alu_ctrl   = ALU_CTRL_W'(alu_c);
  assign bus.imm_src    = imm_sel(bus.op);
  assign bus.illegal    = (state_q == S_TRAP);

endmodule

// File: tb/tb_controller_mc.sv
// Randomised instruction stream against an instruction-level expectation
// builder, plus directed corner cases and parameter variants.
module tb_controller_mc;
  import controller_mc_pkg::*;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic       retire;
    logic       illegal;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] res;
    logic [1:0] imm;
    logic [2:0] alu;
  } vec_t;

  logic clk = 1'b0;
  logic rst, rst_b, rst_t;
  always #5 clk = ~clk;

  controller_mc_if #(.ALU_CTRL_W(3)) bus   ();
  controller_mc_if #(.ALU_CTRL_W(4)) bus_b ();
  controller_mc_if #(.ALU_CTRL_W(3)) bus_t ();

  controller_mc #(.ALU_CTRL_W(3), .BNE_EN(1), .RESET_STATE_TRAP(0)) dut   (.clk(clk), .rst(rst),   .bus(bus));
  controller_mc #(.ALU_CTRL_W(4), .BNE_EN(0), .RESET_STATE_TRAP(0)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));
  controller_mc #(.ALU_CTRL_W(3), .BNE_EN(1), .RESET_STATE_TRAP(1)) dut_t (.clk(clk), .rst(rst_t), .bus(bus_t));

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t expq[$];
  logic forced[$];
  int   ncyc, cmp_cyc, mw_cnt, ret_cnt, ret_cyc;
  vec_t probe;

  logic [6:0] ins_op;
  logic [2:0] ins_f3;
  logic       ins_f7, ins_z;

  function automatic string fmt(input vec_t v);
    return $sformatf("pc=%b ir=%b adr=%b mw=%b rw=%b ret=%b ill=%b a=%b b=%b rs=%b imm=%b alu=%b",
                     v.pc_write, v.ir_write, v.adr_src, v.mem_write, v.reg_write, v.retire,
                     v.illegal, v.src_a, v.src_b, v.res, v.imm, v.alu);
  endfunction

  function automatic vec_t dut_vec();
    vec_t v;
    v.pc_write  = bus.pc_write;
    v.ir_write  = bus.ir_write;
    v.adr_src   = bus.adr_src;
    v.mem_write = bus.mem_write;
    v.reg_write = bus.reg_write;
    v.retire    = bus.retire;
    v.illegal   = bus.illegal;
    v.src_a     = bus.alu_src_a;
    v.src_b     = bus.alu_src_b;
    v.res       = bus.result_src;
    v.imm       = bus.imm_src;
    v.alu       = bus.alu_ctrl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- expectation builders (instruction level) ----------------
  function automatic logic [1:0] imm_of(input logic [6:0] op);
    case (op)
      OP_STORE:  return 2'b01;
      OP_BRANCH: return 2'b10;
      OP_JAL:    return 2'b11;
      default:   return 2'b00;
    endcase
  endfunction

  function automatic logic [2:0] exec_alu();
    logic is_r;
    is_r = (ins_op == OP_RTYPE);
    case (ins_f3)
      3'b000:  return (is_r && ins_f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic vec_t base();
    vec_t v = '0;
    v.imm = imm_of(ins_op);
    return v;
  endfunction

  function automatic vec_t v_fetch(input logic mr);
    vec_t v = base();
    v.src_b = 2'b10; v.res = 2'b10; v.ir_write = mr; v.pc_write = mr;
    return v;
  endfunction

  function automatic vec_t v_reset();
    vec_t v = base();
    v.src_b = 2'b10; v.res = 2'b10;
    return v;
  endfunction

  function automatic vec_t v_decode();
    vec_t v = base();
    v.src_a = 2'b01; v.src_b = 2'b01;
    return v;
  endfunction

  function automatic vec_t v_memadr();
    vec_t v = base();
    v.src_a = 2'b10; v.src_b = 2'b01;
    return v;
  endfunction

  function automatic vec_t v_memread();
    vec_t v = base();
    v.adr_src = 1'b1;
    return v;
  endfunction

  function automatic vec_t v_memwrite(input logic mr);
    vec_t v = base();
    v.adr_src = 1'b1; v.mem_write = 1'b1; v.retire = mr;
    return v;
  endfunction

  function automatic logic get_mr();
    if (forced.size() != 0) return forced.pop_front();
    return ($urandom_range(0, 99) < 60);
  endfunction

  // One clock of stimulus plus the outputs that cycle must show
  task automatic step(input logic r, input logic mr, input vec_t e);
    @(negedge clk);
    rst           = r;
    bus.mem_ready = mr;
    bus.op        = ins_op;
    bus.funct3    = ins_f3;
    bus.funct7b5  = ins_f7;
    bus.is_zero   = ins_z;
    expq.push_back(e);
    ncyc++;
  endtask

  // Whole-instruction expectation: fetch, decode, then class-specific phases
  task automatic run_instr();
    logic mr;
    vec_t v;
    int   w;
    logic trapped;
    logic valid;
    ncyc = 0;
    trapped = 1'b0;
    w = 0;
    do begin
      mr = (w >= 8) ? 1'b1 : get_mr();
      w++;
      step(1'b0, mr, v_fetch(mr));
    end while (!mr);
    step(1'b0, get_mr(), v_decode());
    case (ins_op)
      OP_LOAD, OP_STORE: begin
        step(1'b0, get_mr(), v_memadr());
        w = 0;
        if (ins_op == OP_LOAD) begin
          do begin
            mr = (w >= 8) ? 1'b1 : get_mr();
            w++;
            step(1'b0, mr, v_memread());
          end while (!mr);
          v = base(); v.res = 2'b01; v.reg_write = 1'b1; v.retire = 1'b1;
          step(1'b0, get_mr(), v);
        end else begin
          do begin
            mr = (w >= 8) ? 1'b1 : get_mr();
            w++;
            step(1'b0, mr, v_memwrite(mr));
          end while (!mr);
        end
      end
      OP_RTYPE, OP_ITYPE: begin
        v = base(); v.src_a = 2'b10;
        v.src_b = (ins_op == OP_RTYPE) ? 2'b00 : 2'b01;
        v.alu = exec_alu();
        step(1'b0, get_mr(), v);
        #2 probe = dut_vec();
        v = base(); v.reg_write = 1'b1; v.retire = 1'b1;
        step(1'b0, get_mr(), v);
      end
      OP_BRANCH: begin
        valid = (ins_f3 == 3'b000) || (ins_f3 == 3'b001);
        v = base(); v.src_a = 2'b10; v.alu = 3'b001;
        if (valid) begin
          v.retire   = 1'b1;
          v.pc_write = (ins_f3 == 3'b000) ? ins_z : !ins_z;
        end
        step(1'b0, get_mr(), v);
        #2 probe = dut_vec();
        trapped = !valid;
      end
      OP_JAL: begin
        v = base(); v.src_a = 2'b01; v.src_b = 2'b10;
        v.pc_write = 1'b1; v.reg_write = 1'b1; v.retire = 1'b1;
        step(1'b0, get_mr(), v);
      end
      default: trapped = 1'b1;
    endcase
    if (trapped) begin
      repeat (3) begin
        v = base(); v.illegal = 1'b1;
        step(1'b0, get_mr(), v);
      end
      #2 probe = dut_vec();
      step(1'b1, get_mr(), v_reset());
      step(1'b1, get_mr(), v_reset());
    end
    #2;
  endtask

  task automatic set_ins(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
    ins_op = op; ins_f3 = f3; ins_f7 = f7; ins_z = z;
  endtask

  task automatic rand_instr();
    int k;
    k = $urandom_range(0, 99);
    ins_f3 = 3'($urandom_range(0, 7));
    ins_f7 = 1'($urandom_range(0, 1));
    ins_z  = 1'($urandom_range(0, 1));
    if      (k < 20) ins_op = OP_LOAD;
    else if (k < 35) ins_op = OP_STORE;
    else if (k < 55) ins_op = OP_RTYPE;
    else if (k < 70) ins_op = OP_ITYPE;
    else if (k < 85) begin
      ins_op = OP_BRANCH;
      if ($urandom_range(0, 9) < 8) ins_f3 = 3'($urandom_range(0, 1));
    end
    else if (k < 93) ins_op = OP_JAL;
    else             ins_op = 7'($urandom_range(0, 127));
  endtask

  task automatic step_b(input logic r, input logic [6:0] op, input logic [2:0] f3,
                        input logic f7, input logic z, input logic mr);
    @(negedge clk);
    rst_b = r; bus_b.op = op; bus_b.funct3 = f3; bus_b.funct7b5 = f7;
    bus_b.is_zero = z; bus_b.mem_ready = mr;
    #1;
  endtask

  // Per-cycle comparison of the main DUT against the queued expectations
  initial begin
    vec_t e, a;
    forever begin
      @(negedge clk);
      #1;
      if (expq.size() != 0) begin
        e = expq.pop_front();
        a = dut_vec();
        cmp_cyc++;
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL cycle_vec t=%0t: got %s want %s", $time, fmt(a), fmt(e));
        end
        if (a.mem_write) mw_cnt++;
        if (a.retire) begin
          ret_cnt++;
          ret_cyc = cmp_cyc;
        end
      end
    end
  end

  initial begin
    rst = 1'b1; rst_b = 1'b1; rst_t = 1'b1;
    bus.op = OP_LOAD; bus.funct3 = 3'b0; bus.funct7b5 = 1'b0; bus.is_zero = 1'b0; bus.mem_ready = 1'b1;
    bus_b.op = 7'b0; bus_b.funct3 = 3'b0; bus_b.funct7b5 = 1'b0; bus_b.is_zero = 1'b0; bus_b.mem_ready = 1'b0;
    bus_t.op = OP_LOAD; bus_t.funct3 = 3'b0; bus_t.funct7b5 = 1'b0; bus_t.is_zero = 1'b0; bus_t.mem_ready = 1'b1;
    set_ins(OP_LOAD, 3'b0, 1'b0, 1'b0);
    ncyc = 0; cmp_cyc = 0; mw_cnt = 0; ret_cnt = 0; ret_cyc = 0; probe = '0;

    // Reset state of main and TRAP-reset instances
    @(negedge clk); #1;
    chk("rst_ir_write", 8'(bus.ir_write), 8'd0);
    chk("rst_pc_write", 8'(bus.pc_write), 8'd0);
    chk("rst_retire",   8'(bus.retire),   8'd0);
    chk("rst_illegal",  8'(bus.illegal),  8'd0);
    chk("rst_res_sel",  8'(bus.result_src), 8'd2);
    chk("t_rst_illegal", 8'(bus_t.illegal), 8'd1);
    chk("t_rst_ir",      8'(bus_t.ir_write), 8'd0);
    @(negedge clk); rst_t = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("t_run_illegal", 8'(bus_t.illegal), 8'd1);
    chk("t_run_ir",      8'(bus_t.ir_write), 8'd0);
    chk("t_run_pc",      8'(bus_t.pc_write), 8'd0);

    // BNE disabled, 4-bit alu_ctrl instance
    step_b(1'b0, OP_RTYPE, 3'b000, 1'b1, 1'b0, 1'b1);   // FETCH
    step_b(1'b0, OP_RTYPE, 3'b000, 1'b1, 1'b0, 1'b1);   // DECODE
    step_b(1'b0, OP_RTYPE, 3'b000, 1'b1, 1'b0, 1'b1);   // EXEC_R
    chk("b_sub_alu4", 8'(bus_b.alu_ctrl), 8'h01);
    step_b(1'b0, OP_BRANCH, 3'b001, 1'b0, 1'b0, 1'b1);  // ALUWB
    chk("b_aluwb_retire", 8'(bus_b.retire), 8'd1);
    step_b(1'b0, OP_BRANCH, 3'b001, 1'b0, 1'b0, 1'b1);  // FETCH
    step_b(1'b0, OP_BRANCH, 3'b001, 1'b0, 1'b0, 1'b1);  // DECODE
    step_b(1'b0, OP_BRANCH, 3'b001, 1'b0, 1'b0, 1'b1);  // BRANCH
    chk("b_bne_pc",     8'(bus_b.pc_write), 8'd0);
    chk("b_bne_retire", 8'(bus_b.retire),   8'd0);
    step_b(1'b0, OP_BRANCH, 3'b001, 1'b0, 1'b0, 1'b1);  // TRAP
    chk("b_bne_trap", 8'(bus_b.illegal), 8'd1);

    // lw with memory always ready: five cycles, retire on the fifth
    set_ins(OP_LOAD, 3'b010, 1'b0, 1'b0);
    repeat (5) forced.push_back(1'b1);
    cmp_cyc = 0; ret_cnt = 0; ret_cyc = 0;
    run_instr();
    chk("lw_cycles",  8'(ncyc), 8'd5);
    chk("lw_retires", 8'(ret_cnt), 8'd1);
    chk("lw_ret_cyc", 8'(ret_cyc), 8'd5);

    // sw with memory stalled three cycles in MEMWRITE
    set_ins(OP_STORE, 3'b010, 1'b0, 1'b0);
    forced.push_back(1'b1); forced.push_back(1'b0); forced.push_back(1'b1);
    forced.push_back(1'b0); forced.push_back(1'b0); forced.push_back(1'b0); forced.push_back(1'b1);
    mw_cnt = 0; ret_cnt = 0;
    run_instr();
    chk("sw_cycles",  8'(ncyc), 8'd7);
    chk("sw_mw_high", 8'(mw_cnt), 8'd4);
    chk("sw_retires", 8'(ret_cnt), 8'd1);

    // ALU decode corner cases
    set_ins(OP_RTYPE, 3'b000, 1'b1, 1'b0);
    run_instr();
    chk("r_sub_alu", 8'(probe.alu), 8'h01);
    set_ins(OP_ITYPE, 3'b000, 1'b1, 1'b0);
    run_instr();
    chk("addi_f7_alu", 8'(probe.alu), 8'h00);

    // Branch outcomes
    set_ins(OP_BRANCH, 3'b000, 1'b0, 1'b1);
    run_instr();
    chk("beq_z1_pc", 8'(probe.pc_write), 8'd1);
    set_ins(OP_BRANCH, 3'b001, 1'b0, 1'b1);
    run_instr();
    chk("bne_z1_pc",     8'(probe.pc_write), 8'd0);
    chk("bne_z1_retire", 8'(probe.retire),   8'd1);

    // Unknown opcode traps and stays quiet
    set_ins(7'b1111111, 3'b000, 1'b0, 1'b0);
    run_instr();
    chk("trap_illegal", 8'(probe.illegal), 8'd1);
    chk("trap_strobes", 8'({probe.pc_write, probe.ir_write, probe.mem_write,
                            probe.reg_write, probe.retire}), 8'd0);

    // Asynchronous reset while waiting in MEMREAD
    set_ins(OP_LOAD, 3'b010, 1'b0, 1'b0);
    step(1'b0, 1'b1, v_fetch(1'b1));
    step(1'b0, 1'b0, v_decode());
    step(1'b0, 1'b1, v_memadr());
    step(1'b0, 1'b0, v_memread());
    #3 rst = 1'b1;
    #1;
    chk("arst_rd_adr",    8'(bus.adr_src),    8'd0);
    chk("arst_rd_res",    8'(bus.result_src), 8'd2);
    chk("arst_rd_retire", 8'(bus.retire),     8'd0);
    step(1'b1, 1'b0, v_reset());

    // Asynchronous reset while a store is stalled
    set_ins(OP_STORE, 3'b010, 1'b0, 1'b0);
    step(1'b0, 1'b1, v_fetch(1'b1));
    step(1'b0, 1'b0, v_decode());
    step(1'b0, 1'b1, v_memadr());
    step(1'b0, 1'b0, v_memwrite(1'b0));
    #3 rst = 1'b1;
    #1;
    chk("arst_wr_mw",     8'(bus.mem_write), 8'd0);
    chk("arst_wr_retire", 8'(bus.retire),    8'd0);
    step(1'b1, 1'b0, v_reset());

    // Random instruction stream; first instruction after reset starts in FETCH
    repeat (250) begin
      rand_instr();
      run_instr();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
